// File: rtl/litedram_axi_gate.sv
// AXI4 gate in front of the LiteDRAM controller: stalls until calibration, then passes through.
// `LITEDRAM_AXI_GATE_ERRRESP_EN builds local SLVERR responders used when calibration has failed.
module litedram_axi_gate #(
    parameter int ID_WIDTH = 0,
    // ID_WIDTH of 0 still carries a 1-bit id field so the ports stay legal vectors
    localparam int IW = (ID_WIDTH > 0) ? ID_WIDTH : 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_init_done,
    input  logic          i_init_error,
    output logic          o_gate_open,
    output logic          o_gate_fail,
    // slave AW
    input  logic [IW-1:0] i_s_awid,
    input  logic [26:0]   i_s_awaddr,
    input  logic [7:0]    i_s_awlen,
    input  logic [3:0]    i_s_awsize,
    input  logic [1:0]    i_s_awburst,
    input  logic          i_s_awvalid,
    output logic          o_s_awready,
    // slave W
    input  logic [63:0]   i_s_wdata,
    input  logic [7:0]    i_s_wstrb,
    input  logic          i_s_wlast,
    input  logic          i_s_wvalid,
    output logic          o_s_wready,
    // slave B
    output logic [IW-1:0] o_s_bid,
    output logic [1:0]    o_s_bresp,
    output logic          o_s_bvalid,
    input  logic          i_s_bready,
    // slave AR
    input  logic [IW-1:0] i_s_arid,
    input  logic [26:0]   i_s_araddr,
    input  logic [7:0]    i_s_arlen,
    input  logic [3:0]    i_s_arsize,
    input  logic [1:0]    i_s_arburst,
    input  logic          i_s_arvalid,
    output logic          o_s_arready,
    // slave R
    output logic [IW-1:0] o_s_rid,
    output logic [63:0]   o_s_rdata,
    output logic [1:0]    o_s_rresp,
    output logic          o_s_rlast,
    output logic          o_s_rvalid,
    input  logic          i_s_rready,
    // master AW
    output logic [IW-1:0] o_m_awid,
    output logic [26:0]   o_m_awaddr,
    output logic [7:0]    o_m_awlen,
    output logic [3:0]    o_m_awsize,
    output logic [1:0]    o_m_awburst,
    output logic          o_m_awvalid,
    input  logic          i_m_awready,
    // master W
    output logic [63:0]   o_m_wdata,
    output logic [7:0]    o_m_wstrb,
    output logic          o_m_wlast,
    output logic          o_m_wvalid,
    input  logic          i_m_wready,
    // master B
    input  logic [IW-1:0] i_m_bid,
    input  logic [1:0]    i_m_bresp,
    input  logic          i_m_bvalid,
    output logic          o_m_bready,
    // master AR
    output logic [IW-1:0] o_m_arid,
    output logic [26:0]   o_m_araddr,
    output logic [7:0]    o_m_arlen,
    output logic [3:0]    o_m_arsize,
    output logic [1:0]    o_m_arburst,
    output logic          o_m_arvalid,
    input  logic          i_m_arready,
    // master R
    input  logic [IW-1:0] i_m_rid,
    input  logic [63:0]   i_m_rdata,
    input  logic [1:0]    i_m_rresp,
    input  logic          i_m_rlast,
    input  logic          i_m_rvalid,
    output logic          o_m_rready
);

    typedef enum logic [1:0] {ST_WAIT, ST_PASS, ST_FAIL} gate_state_e;

    gate_state_e state_q;
    logic        gate_open_q;
    logic        gate_fail_q;

    // FAIL takes priority when both calibration flags arrive together
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_WAIT;
            gate_open_q <= 1'b0;
            gate_fail_q <= 1'b0;
        end else if (state_q == ST_WAIT) begin
            if (i_init_error) begin
                state_q     <= ST_FAIL;
                gate_fail_q <= 1'b1;
            end else if (i_init_done) begin
                state_q     <= ST_PASS;
                gate_open_q <= 1'b1;
            end
        end
    end

    assign o_gate_open = gate_open_q;
    assign o_gate_fail = gate_fail_q;

`ifdef LITEDRAM_AXI_GATE_ERRRESP_EN
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
    typedef enum logic       {R_IDLE, R_DATA} rd_state_e;

    wr_state_e     w_state_q;
    logic [IW-1:0] bid_q;
    logic [7:0]    wcnt_q;
    rd_state_e     r_state_q;
    logic [IW-1:0] rid_q;
    logic [7:0]    rcnt_q;

    // Counter holds beats remaining after the current one; wlast is not consulted
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            w_state_q <= W_IDLE;
            bid_q     <= '0;
            wcnt_q    <= '0;
        end else begin
            case (w_state_q)
                W_IDLE: if (state_q == ST_FAIL && i_s_awvalid) begin
                    bid_q     <= i_s_awid;
                    wcnt_q    <= i_s_awlen;
                    w_state_q <= W_DATA;
                end
                W_DATA: if (i_s_wvalid) begin
                    if (wcnt_q == 8'd0) w_state_q <= W_RESP;
                    else                wcnt_q    <= wcnt_q - 8'd1;
                end
                W_RESP: if (i_s_bready) w_state_q <= W_IDLE;
                default: w_state_q <= W_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q <= R_IDLE;
            rid_q     <= '0;
            rcnt_q    <= '0;
        end else begin
            case (r_state_q)
                R_IDLE: if (state_q == ST_FAIL && i_s_arvalid) begin
                    rid_q     <= i_s_arid;
                    rcnt_q    <= i_s_arlen;
                    r_state_q <= R_DATA;
                end
                R_DATA: if (i_s_rready) begin
                    if (rcnt_q == 8'd0) r_state_q <= R_IDLE;
                    else                rcnt_q    <= rcnt_q - 8'd1;
                end
                default: r_state_q <= R_IDLE;
            endcase
        end
    end
`endif

    always_comb begin
        o_s_awready = 1'b0;
        o_s_wready  = 1'b0;
        o_s_bid     = '0;
        o_s_bresp   = '0;
        o_s_bvalid  = 1'b0;
        o_s_arready = 1'b0;
        o_s_rid     = '0;
        o_s_rdata   = '0;
        o_s_rresp   = '0;
        o_s_rlast   = 1'b0;
        o_s_rvalid  = 1'b0;
        o_m_awid    = '0;
        o_m_awaddr  = '0;
        o_m_awlen   = '0;
        o_m_awsize  = '0;
        o_m_awburst = '0;
        o_m_awvalid = 1'b0;
        o_m_wdata   = '0;
        o_m_wstrb   = '0;
        o_m_wlast   = 1'b0;
        o_m_wvalid  = 1'b0;
        o_m_bready  = 1'b0;
        o_m_arid    = '0;
        o_m_araddr  = '0;
        o_m_arlen   = '0;
        o_m_arsize  = '0;
        o_m_arburst = '0;
        o_m_arvalid = 1'b0;
        o_m_rready  = 1'b0;
        case (state_q)
            ST_PASS: begin
                o_m_awid    = i_s_awid;
                o_m_awaddr  = i_s_awaddr;
                o_m_awlen   = i_s_awlen;
                o_m_awsize  = i_s_awsize;
                o_m_awburst = i_s_awburst;
                o_m_awvalid = i_s_awvalid;
                o_s_awready = i_m_awready;
                o_m_wdata   = i_s_wdata;
                o_m_wstrb   = i_s_wstrb;
                o_m_wlast   = i_s_wlast;
                o_m_wvalid  = i_s_wvalid;
                o_s_wready  = i_m_wready;
                o_s_bid     = i_m_bid;
                o_s_bresp   = i_m_bresp;
                o_s_bvalid  = i_m_bvalid;
                o_m_bready  = i_s_bready;
                o_m_arid    = i_s_arid;
                o_m_araddr  = i_s_araddr;
                o_m_arlen   = i_s_arlen;
                o_m_arsize  = i_s_arsize;
                o_m_arburst = i_s_arburst;
                o_m_arvalid = i_s_arvalid;
                o_s_arready = i_m_arready;
                o_s_rid     = i_m_rid;
                o_s_rdata   = i_m_rdata;
                o_s_rresp   = i_m_rresp;
                o_s_rlast   = i_m_rlast;
                o_s_rvalid  = i_m_rvalid;
                o_m_rready  = i_s_rready;
            end
            ST_FAIL: begin
`ifdef LITEDRAM_AXI_GATE_ERRRESP_EN
                o_s_awready = (w_state_q == W_IDLE);
                o_s_wready  = (w_state_q == W_DATA);
                o_s_bvalid  = (w_state_q == W_RESP);
                o_s_bresp   = 2'b10;
                o_s_bid     = bid_q;
                o_s_arready = (r_state_q == R_IDLE);
                o_s_rvalid  = (r_state_q == R_DATA);
                o_s_rresp   = 2'b10;
                o_s_rid     = rid_q;
                o_s_rlast   = (r_state_q == R_DATA) && (rcnt_q == 8'd0);
`endif
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_litedram_axi_gate.sv
// Self-checking bench for litedram_axi_gate: WAIT stall, PASS wiring table, FAIL responders.
module tb_litedram_axi_gate;

    logic        i_clk = 1'b0;
    logic        i_rst, i_init_done, i_init_error, o_gate_open, o_gate_fail;
    logic [3:0]  i_s_awid, i_s_arid, o_s_bid, o_s_rid, o_m_awid, o_m_arid, i_m_bid, i_m_rid;
    logic [26:0] i_s_awaddr, i_s_araddr, o_m_awaddr, o_m_araddr;
    logic [7:0]  i_s_awlen, i_s_arlen, o_m_awlen, o_m_arlen, i_s_wstrb, o_m_wstrb;
    logic [3:0]  i_s_awsize, i_s_arsize, o_m_awsize, o_m_arsize;
    logic [1:0]  i_s_awburst, i_s_arburst, o_m_awburst, o_m_arburst;
    logic [1:0]  o_s_bresp, o_s_rresp, i_m_bresp, i_m_rresp;
    logic [63:0] i_s_wdata, o_m_wdata, o_s_rdata, i_m_rdata;
    logic        i_s_awvalid, o_s_awready, i_s_wlast, i_s_wvalid, o_s_wready, o_s_bvalid, i_s_bready;
    logic        i_s_arvalid, o_s_arready, o_s_rlast, o_s_rvalid, i_s_rready;
    logic        o_m_awvalid, i_m_awready, o_m_wlast, o_m_wvalid, i_m_wready, i_m_bvalid, o_m_bready;
    logic        o_m_arvalid, i_m_arready, i_m_rlast, i_m_rvalid, o_m_rready;

    always #5 i_clk = ~i_clk;

    litedram_axi_gate #(.ID_WIDTH(4)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_init_done(i_init_done), .i_init_error(i_init_error),
        .o_gate_open(o_gate_open), .o_gate_fail(o_gate_fail),
        .i_s_awid(i_s_awid), .i_s_awaddr(i_s_awaddr), .i_s_awlen(i_s_awlen), .i_s_awsize(i_s_awsize),
        .i_s_awburst(i_s_awburst), .i_s_awvalid(i_s_awvalid), .o_s_awready(o_s_awready),
        .i_s_wdata(i_s_wdata), .i_s_wstrb(i_s_wstrb), .i_s_wlast(i_s_wlast), .i_s_wvalid(i_s_wvalid),
        .o_s_wready(o_s_wready),
        .o_s_bid(o_s_bid), .o_s_bresp(o_s_bresp), .o_s_bvalid(o_s_bvalid), .i_s_bready(i_s_bready),
        .i_s_arid(i_s_arid), .i_s_araddr(i_s_araddr), .i_s_arlen(i_s_arlen), .i_s_arsize(i_s_arsize),
        .i_s_arburst(i_s_arburst), .i_s_arvalid(i_s_arvalid), .o_s_arready(o_s_arready),
        .o_s_rid(o_s_rid), .o_s_rdata(o_s_rdata), .o_s_rresp(o_s_rresp), .o_s_rlast(o_s_rlast),
        .o_s_rvalid(o_s_rvalid), .i_s_rready(i_s_rready),
        .o_m_awid(o_m_awid), .o_m_awaddr(o_m_awaddr), .o_m_awlen(o_m_awlen), .o_m_awsize(o_m_awsize),
        .o_m_awburst(o_m_awburst), .o_m_awvalid(o_m_awvalid), .i_m_awready(i_m_awready),
        .o_m_wdata(o_m_wdata), .o_m_wstrb(o_m_wstrb), .o_m_wlast(o_m_wlast), .o_m_wvalid(o_m_wvalid),
        .i_m_wready(i_m_wready),
        .i_m_bid(i_m_bid), .i_m_bresp(i_m_bresp), .i_m_bvalid(i_m_bvalid), .o_m_bready(o_m_bready),
        .o_m_arid(o_m_arid), .o_m_araddr(o_m_araddr), .o_m_arlen(o_m_arlen), .o_m_arsize(o_m_arsize),
        .o_m_arburst(o_m_arburst), .o_m_arvalid(o_m_arvalid), .i_m_arready(i_m_arready),
        .i_m_rid(i_m_rid), .i_m_rdata(i_m_rdata), .i_m_rresp(i_m_rresp), .i_m_rlast(i_m_rlast),
        .i_m_rvalid(i_m_rvalid), .o_m_rready(o_m_rready)
    );

    typedef struct {
        logic [3:0]  id;
        logic [26:0] addr;
        logic [7:0]  len;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        vld;
        logic        rdy;
        logic [3:0]  exp_id;
        logic [26:0] exp_addr;
        logic [63:0] exp_data;
        logic [1:0]  exp_resp;
        logic        exp_vld;
        logic        exp_rdy;
    } vec_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } rbeat_t;

    vec_t       vecs[4];
    rbeat_t     rq[$];
    logic [5:0] bq[$];
    int         n_vec = 0;
    int         n_err = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        {i_s_awid, i_s_awaddr, i_s_awlen, i_s_awsize, i_s_awburst, i_s_awvalid} = '0;
        {i_s_wdata, i_s_wstrb, i_s_wlast, i_s_wvalid, i_s_bready} = '0;
        {i_s_arid, i_s_araddr, i_s_arlen, i_s_arsize, i_s_arburst, i_s_arvalid, i_s_rready} = '0;
        {i_m_awready, i_m_wready, i_m_bid, i_m_bresp, i_m_bvalid, i_m_arready} = '0;
        {i_m_rid, i_m_rdata, i_m_rresp, i_m_rlast, i_m_rvalid} = '0;
    endtask

    initial begin
        logic   bad;
        int     acc;
        int     beats;
        int     cyc;
        rbeat_t eb;
        logic [5:0] eresp;

        vecs[0] = '{4'd5, 27'h100, 8'd0, 64'h0123_4567_89ab_cdef, 2'b00, 1'b1, 1'b1,
                    4'd5, 27'h100, 64'h0123_4567_89ab_cdef, 2'b00, 1'b1, 1'b1};
        vecs[1] = '{4'd15, 27'h7ff_ffff, 8'd255, 64'hffff_ffff_ffff_ffff, 2'b11, 1'b1, 1'b0,
                    4'd15, 27'h7ff_ffff, 64'hffff_ffff_ffff_ffff, 2'b11, 1'b1, 1'b0};
        vecs[2] = '{4'd0, 27'h000_0000, 8'd7, 64'h0, 2'b10, 1'b0, 1'b1,
                    4'd0, 27'h000_0000, 64'h0, 2'b10, 1'b0, 1'b1};
        vecs[3] = '{4'd10, 27'h555_5555, 8'd3, 64'ha5a5_5a5a_dead_beef, 2'b01, 1'b0, 1'b0,
                    4'd10, 27'h555_5555, 64'ha5a5_5a5a_dead_beef, 2'b01, 1'b0, 1'b0};

        clear_inputs();
        i_init_done  = 1'b0;
        i_init_error = 1'b0;
        i_rst        = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        settle();
        check("rst_open", o_gate_open, 1'b0);
        check("rst_fail", o_gate_fail, 1'b0);
        check("rst_readies", {o_s_awready, o_s_wready, o_s_arready, o_m_bready, o_m_rready}, 5'b0);
        check("rst_valids", {o_s_bvalid, o_s_rvalid, o_m_awvalid, o_m_wvalid, o_m_arvalid}, 5'b0);

        // WAIT: traffic from both sides must be stalled completely
        i_s_awvalid = 1'b1; i_s_awlen = 8'd3; i_s_arvalid = 1'b1; i_s_arlen = 8'd0;
        i_s_wvalid = 1'b1; i_s_bready = 1'b1; i_s_rready = 1'b1;
        i_m_awready = 1'b1; i_m_wready = 1'b1; i_m_arready = 1'b1; i_m_bvalid = 1'b1; i_m_rvalid = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 100; c++) begin
            settle();
            if ({o_s_awready, o_s_wready, o_s_arready, o_s_bvalid, o_s_rvalid, o_m_awvalid,
                 o_m_wvalid, o_m_arvalid, o_m_bready, o_m_rready} != '0) bad = 1'b1;
            tick();
        end
        check("wait_stall_100", bad, 1'b0);
        check("wait_open", o_gate_open, 1'b0);
        clear_inputs();

        // Open the gate: state and o_gate_open change on the edge that samples init_done
        i_init_done = 1'b1;
        settle();
        check("open_before_edge", o_gate_open, 1'b0);
        tick();
        check("open_at_edge", {o_gate_open, o_gate_fail}, 2'b10);

        foreach (vecs[k]) begin
            i_s_arid = vecs[k].id; i_s_araddr = vecs[k].addr; i_s_arlen = vecs[k].len;
            i_s_arvalid = vecs[k].vld; i_m_arready = vecs[k].rdy;
            i_s_awid = vecs[k].id; i_s_awaddr = vecs[k].addr; i_s_awlen = vecs[k].len;
            i_s_awvalid = vecs[k].vld; i_m_awready = vecs[k].rdy;
            i_s_wdata = vecs[k].data; i_s_wvalid = vecs[k].vld; i_m_wready = vecs[k].rdy;
            i_m_rid = vecs[k].id; i_m_rdata = vecs[k].data; i_m_rresp = vecs[k].resp;
            i_m_rvalid = vecs[k].vld; i_s_rready = vecs[k].rdy;
            i_m_bid = vecs[k].id; i_m_bresp = vecs[k].resp; i_m_bvalid = vecs[k].vld;
            i_s_bready = vecs[k].rdy;
            settle();
            check($sformatf("pass_ar[%0d]", k), {o_m_arid, o_m_araddr, o_m_arvalid, o_s_arready},
                  {vecs[k].exp_id, vecs[k].exp_addr, vecs[k].exp_vld, vecs[k].exp_rdy});
            check($sformatf("pass_aw[%0d]", k), {o_m_awid, o_m_awaddr, o_m_awvalid, o_s_awready},
                  {vecs[k].exp_id, vecs[k].exp_addr, vecs[k].exp_vld, vecs[k].exp_rdy});
            check($sformatf("pass_w[%0d]", k), {o_m_wdata, o_m_wvalid, o_s_wready},
                  {vecs[k].exp_data, vecs[k].exp_vld, vecs[k].exp_rdy});
            check($sformatf("pass_r[%0d]", k), {o_s_rid, o_s_rdata, o_s_rresp, o_s_rvalid, o_m_rready},
                  {vecs[k].exp_id, vecs[k].exp_data, vecs[k].exp_resp, vecs[k].exp_vld, vecs[k].exp_rdy});
            check($sformatf("pass_b[%0d]", k), {o_s_bid, o_s_bresp, o_s_bvalid, o_m_bready},
                  {vecs[k].exp_id, vecs[k].exp_resp, vecs[k].exp_vld, vecs[k].exp_rdy});
            tick();
        end
        clear_inputs();

        // Both flags together: FAIL wins, and later flag changes are ignored
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        i_init_done = 1'b1; i_init_error = 1'b1;
        tick();
        check("fail_enter", {o_gate_open, o_gate_fail}, 2'b01);
        i_init_done = 1'b0; i_init_error = 1'b0;
        tick(); tick(); tick();
        check("fail_sticky", {o_gate_open, o_gate_fail}, 2'b01);

`ifdef LITEDRAM_AXI_GATE_ERRRESP_EN
        // Write burst: len=3 with an early wlast must still take four beats
        i_s_awid = 4'd2; i_s_awlen = 8'd3; i_s_awvalid = 1'b1; i_m_awready = 1'b1;
        settle();
        check("fail_awready", o_s_awready, 1'b1);
        check("fail_m_valids", {o_m_awvalid, o_m_wvalid, o_m_arvalid, o_m_bready, o_m_rready}, 5'b0);
        tick();
        bq.push_back({4'd2, 2'b10});
        i_s_awvalid = 1'b0;
        settle();
        check("w_after_aw", {o_s_wready, o_s_awready}, 2'b10);
        acc = 0;
        for (int b = 0; b < 4; b++) begin
            i_s_wvalid = 1'b1; i_s_wlast = (b == 1); i_s_wdata = 64'(b);
            settle();
            if (o_s_wready) acc++;
            tick();
        end
        i_s_wlast = 1'b0;
        settle();
        check("w_beats", acc, 4);
        check("w_no_extra", o_s_wready, 1'b0);
        check("b_valid", o_s_bvalid, 1'b1);
        i_s_wvalid = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (!o_s_bvalid) bad = 1'b1;
        end
        check("b_hold", bad, 1'b0);
        i_s_bready = 1'b1;
        settle();
        eresp = bq.pop_front();
        check("b_resp", {o_s_bid, o_s_bresp}, eresp);
        tick();
        i_s_bready = 1'b0;
        settle();
        check("aw_after_b", {o_s_awready, o_s_bvalid}, 2'b10);

        // Read burst of 256 beats with a randomly toggling rready
        i_s_arid = 4'd1; i_s_arlen = 8'd255; i_s_arvalid = 1'b1;
        settle();
        check("fail_arready", o_s_arready, 1'b1);
        tick();
        i_s_arvalid = 1'b0;
        for (int j = 0; j < 256; j++) rq.push_back('{4'd1, 64'd0, 2'b10, (j == 255)});
        beats = 0;
        cyc = 0;
        while (rq.size() != 0 && cyc < 3000) begin
            i_s_rready = 1'($urandom_range(0, 1));
            settle();
            if (o_s_rvalid && i_s_rready) begin
                eb = rq.pop_front();
                check($sformatf("r_beat[%0d]", beats), {o_s_rid, o_s_rdata, o_s_rresp, o_s_rlast}, eb);
                beats++;
            end
            tick();
            cyc++;
        end
        check("r_beat_count", beats, 256);
        i_s_rready = 1'b0;
        settle();
        check("ar_after_rlast", {o_s_arready, o_s_rvalid}, 2'b10);

        // Reset in the middle of a read burst drops it
        i_s_arid = 4'd3; i_s_arlen = 8'd20; i_s_arvalid = 1'b1;
        tick();
        i_s_arvalid = 1'b0;
        for (int j = 0; j < 21; j++) rq.push_back('{4'd3, 64'd0, 2'b10, (j == 20)});
        i_s_rready = 1'b1;
        beats = 0;
        cyc = 0;
        while (beats < 9 && cyc < 50) begin
            settle();
            if (o_s_rvalid) begin
                eb = rq.pop_front();
                check($sformatf("rr_beat[%0d]", beats), {o_s_rid, o_s_rdata, o_s_rresp, o_s_rlast}, eb);
                beats++;
            end
            tick();
            cyc++;
        end
        settle();
        check("r_beat10_valid", o_s_rvalid, 1'b1);
        rq.delete();
`endif

        i_rst = 1'b1;
        tick();
        check("midrst_rvalid", o_s_rvalid, 1'b0);
        check("midrst_state", {o_gate_open, o_gate_fail}, 2'b00);
        i_rst = 1'b0;
        i_s_rready = 1'b0;
        tick();
        check("wait_again", {o_gate_fail, o_s_arready}, 2'b00);
        i_init_error = 1'b1;
        tick();
        i_init_error = 1'b0;
`ifdef LITEDRAM_AXI_GATE_ERRRESP_EN
        check("refail", {o_gate_fail, o_s_arready, o_s_awready}, 3'b111);
`else
        check("refail", {o_gate_fail, o_s_arready, o_s_awready}, 3'b100);
        // Without responders FAIL must stall like WAIT
        i_s_awvalid = 1'b1; i_s_arvalid = 1'b1; i_s_wvalid = 1'b1;
        i_m_bvalid = 1'b1; i_m_rvalid = 1'b1; i_m_awready = 1'b1; i_m_arready = 1'b1;
        bad = 1'b0;
        for (int c = 0; c < 20; c++) begin
            settle();
            if ({o_s_awready, o_s_wready, o_s_arready, o_s_bvalid, o_s_rvalid, o_m_awvalid,
                 o_m_wvalid, o_m_arvalid} != '0) bad = 1'b1;
            tick();
        end
        check("fail_stall", bad, 1'b0);
        clear_inputs();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
